// File: rtl/mem_ctrl_if.sv
// Signal bundle between the MEM/IF requesters, the memory controller and the byte-wide RAM.
interface mem_ctrl_if #(parameter int ADDR_W = 17);
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [2:0]        mem_sel_i;
    logic [31:0]       mem_data_i;
    logic [31:0]       mem_data_o;
    logic              mem_done_o;
    logic              mem_busy_o;
    logic              if_ce_i;
    logic [31:0]       if_addr_i;
    logic [31:0]       if_data_o;
    logic              if_done_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  if_ce_i, if_addr_i, ram_din_i,
        output mem_data_o, mem_done_o, mem_busy_o, if_data_o, if_done_o,
        output ram_addr_o, ram_wr_o, ram_dout_o
    );

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output if_ce_i, if_addr_i, ram_din_i,
        input  mem_data_o, mem_done_o, mem_busy_o, if_data_o, if_done_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Serializes 1/2/4-byte MEM loads/stores and 4-byte IF fetches onto a byte-wide synchronous RAM,
// little-endian, with MEM at fixed priority over IF.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input logic        clk,
    input logic        rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_if_q, owner_if_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              mem_done_q, mem_done_d;
    logic              if_done_q, if_done_d;
    logic              busy_q, busy_d;

    logic [2:0]        next_idx;
    logic [2:0]        lane;
    logic [31:0]       lane_data;

    // In READ, cnt_q is the index of the byte whose address is on the bus this cycle;
    // the byte arriving now belongs to the previous index.
    assign next_idx  = cnt_q + 3'd1;
    assign lane      = cnt_q - 3'd1;
    assign lane_data = {24'd0, bus.ram_din_i} << {lane, 3'b000};

    always_comb begin
        state_d    = state_q;
        owner_if_d = owner_if_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        ram_addr_d = ram_addr_q;
        ram_wr_d   = 1'b0;
        ram_dout_d = ram_dout_q;
        mem_data_d = mem_data_q;
        if_data_d  = if_data_q;
        mem_done_d = 1'b0;
        if_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_ce_i) begin
                    owner_if_d = 1'b0;
                    base_d     = bus.mem_addr_i;
                    wdata_d    = bus.mem_data_i;
                    state_d    = bus.mem_we_i ? WRITE : READ;
                    case (bus.mem_sel_i)
                        3'b001:  n_d = 3'd1;
                        3'b010:  n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                end else if (bus.if_ce_i) begin
                    owner_if_d = 1'b1;
                    base_d     = bus.if_addr_i;
                    n_d        = 3'd4;
                    state_d    = READ;
                end
                // Byte 0 goes out on the bus in the first cycle after the accept.
                if (state_d != IDLE) begin
                    cnt_d      = 3'd0;
                    rbuf_d     = 32'd0;
                    ram_addr_d = base_d[ADDR_W-1:0];
                    ram_wr_d   = (state_d == WRITE);
                    ram_dout_d = wdata_d[7:0];
                end
            end
            READ: begin
                cnt_d = next_idx;
                if (next_idx < n_q) begin
                    ram_addr_d = ADDR_W'(base_q + {29'd0, next_idx});
                end
                if (cnt_q != 3'd0) begin
                    rbuf_d = rbuf_q | lane_data;
                end
                if (cnt_q == n_q) begin
                    state_d = DONE;
                    if (owner_if_q) begin
                        if_data_d = rbuf_d;
                        if_done_d = 1'b1;
                    end else begin
                        mem_data_d = rbuf_d;
                        mem_done_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (next_idx < n_q) begin
                    cnt_d      = next_idx;
                    ram_wr_d   = 1'b1;
                    ram_addr_d = ADDR_W'(base_q + {29'd0, next_idx});
                    ram_dout_d = wdata_q[{next_idx[1:0], 3'b000} +: 8];
                end else begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = owner_if_d && (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_if_q <= 1'b0;
            n_q        <= 3'd0;
            cnt_q      <= 3'd0;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            ram_addr_q <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
            mem_data_q <= 32'd0;
            if_data_q  <= 32'd0;
            mem_done_q <= 1'b0;
            if_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            ram_addr_q <= ram_addr_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
            mem_data_q <= mem_data_d;
            if_data_q  <= if_data_d;
            mem_done_q <= mem_done_d;
            if_done_q  <= if_done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.mem_data_o = mem_data_q;
    assign bus.mem_done_o = mem_done_q;
    assign bus.mem_busy_o = busy_q;
    assign bus.if_data_o  = if_data_q;
    assign bus.if_done_o  = if_done_q;
    assign bus.ram_addr_o = ram_addr_q;
    assign bus.ram_wr_o   = ram_wr_q;
    assign bus.ram_dout_o = ram_dout_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: synchronous byte RAM, transaction-level timeline model and
// a per-cycle comparator, driven by directed cases followed by randomized traffic and resets.
module tb_mem_ctrl;
    localparam int ADDR_W   = 17;
    localparam int MEM_SIZE = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   free_at = 0;

    logic [7:0] env_mem   [MEM_SIZE];
    logic [7:0] model_mem [MEM_SIZE];

    // Expected-output timeline, one slot per future cycle (cycle number modulo 32).
    bit              sl_av   [32];
    bit              sl_wr   [32];
    bit              sl_md   [32];
    bit              sl_mrd  [32];
    bit              sl_id   [32];
    bit              sl_busy [32];
    logic [ADDR_W-1:0] sl_addr [32];
    logic [7:0]      sl_dout [32];
    logic [31:0]     sl_data [32];
    logic [ADDR_W-1:0] exp_addr_cur = '0;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp_v);
        end
    endtask

    function automatic void clearSlot(input int s);
        sl_av[s]   = 1'b0;
        sl_wr[s]   = 1'b0;
        sl_md[s]   = 1'b0;
        sl_mrd[s]  = 1'b0;
        sl_id[s]   = 1'b0;
        sl_busy[s] = 1'b0;
        sl_addr[s] = '0;
        sl_dout[s] = 8'd0;
        sl_data[s] = 32'd0;
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] b);
        env_mem[a]   = b;
        model_mem[a] = b;
    endtask

    // Synchronous RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        if (bus.ram_wr_o === 1'b1) env_mem[bus.ram_addr_o] <= bus.ram_dout_o;
        bus.ram_din_i <= env_mem[bus.ram_addr_o];
    end

    // Model: at each edge decide whether a request is accepted and lay out its whole timeline.
    always @(posedge clk) begin
        int t;
        int s;
        int n;
        int j;
        bit we;
        bit own_if;
        logic [31:0] base;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] a;
        t = cyc;
        s = t % 32;
        if (sl_wr[s]) model_mem[sl_addr[s]] = sl_dout[s];
        clearSlot(s);
        if (rst) begin
            for (int k = 1; k <= 8; k++) clearSlot((t + k) % 32);
            sl_av[(t + 1) % 32]   = 1'b1;
            sl_addr[(t + 1) % 32] = '0;
            free_at = t + 1;
        end else if (t >= free_at && (bus.mem_ce_i || bus.if_ce_i)) begin
            own_if = !bus.mem_ce_i;
            if (own_if) begin
                we   = 1'b0;
                base = bus.if_addr_i;
                wd   = 32'd0;
                n    = 4;
            end else begin
                we   = bus.mem_we_i;
                base = bus.mem_addr_i;
                wd   = bus.mem_data_i;
                n    = (bus.mem_sel_i == 3'b001) ? 1 : (bus.mem_sel_i == 3'b010) ? 2 : 4;
            end
            rd = 32'd0;
            for (int k = 0; k < n; k++) begin
                j = (t + 1 + k) % 32;
                a = base + 32'(k);
                sl_av[j]   = 1'b1;
                sl_addr[j] = a[ADDR_W-1:0];
                if (we) begin
                    sl_wr[j]   = 1'b1;
                    sl_dout[j] = wd[8*k +: 8];
                end else begin
                    rd = rd | ({24'd0, model_mem[a[ADDR_W-1:0]]} << (8 * k));
                end
                if (own_if) sl_busy[j] = 1'b1;
            end
            if (we) begin
                sl_md[(t + n + 1) % 32] = 1'b1;
                free_at = t + n + 2;
            end else begin
                j = (t + n + 2) % 32;
                sl_data[j] = rd;
                if (own_if) begin
                    sl_id[j] = 1'b1;
                    sl_busy[(t + n + 1) % 32] = 1'b1;
                    sl_busy[j] = 1'b1;
                end else begin
                    sl_md[j]  = 1'b1;
                    sl_mrd[j] = 1'b1;
                end
                free_at = t + n + 3;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int s;
        if (cyc >= 1) begin
            s = cyc % 32;
            if (sl_av[s]) exp_addr_cur = sl_addr[s];
            checkOutput("ram_wr", 32'(bus.ram_wr_o), 32'(sl_wr[s]));
            if (sl_wr[s]) checkOutput("ram_dout", 32'(bus.ram_dout_o), 32'(sl_dout[s]));
            checkOutput("ram_addr", 32'(bus.ram_addr_o), 32'(exp_addr_cur));
            checkOutput("mem_done", 32'(bus.mem_done_o), 32'(sl_md[s]));
            if (sl_md[s] && sl_mrd[s]) checkOutput("mem_data", bus.mem_data_o, sl_data[s]);
            checkOutput("if_done", 32'(bus.if_done_o), 32'(sl_id[s]));
            if (sl_id[s]) checkOutput("if_data", bus.if_data_o, sl_data[s]);
            checkOutput("mem_busy", 32'(bus.mem_busy_o), 32'(sl_busy[s]));
        end
    end

    // Raises the chosen requests together and holds each until its done pulse; latencies are
    // counted from the cycle in which the requests were first raised.
    task automatic applyStimulus(input bit do_mem, input bit we, input logic [31:0] addr,
                                 input logic [2:0] sel, input logic [31:0] wdata,
                                 input bit do_if, input logic [31:0] faddr,
                                 output int mem_lat, output logic [31:0] mem_rd,
                                 output int if_lat, output logic [31:0] if_rd);
        int start;
        bit mem_pend;
        bit if_pend;
        @(negedge clk);
        bus.mem_ce_i   = do_mem;
        bus.mem_we_i   = we;
        bus.mem_addr_i = addr;
        bus.mem_sel_i  = sel;
        bus.mem_data_i = wdata;
        bus.if_ce_i    = do_if;
        bus.if_addr_i  = faddr;
        start    = cyc;
        mem_lat  = -1;
        if_lat   = -1;
        mem_rd   = 32'd0;
        if_rd    = 32'd0;
        mem_pend = do_mem;
        if_pend  = do_if;
        for (int i = 0; i < 60 && (mem_pend || if_pend); i++) begin
            @(negedge clk);
            if (mem_pend && bus.mem_done_o === 1'b1) begin
                mem_lat = cyc - start;
                mem_rd  = bus.mem_data_o;
                mem_pend = 1'b0;
                bus.mem_ce_i = 1'b0;
            end
            if (if_pend && bus.if_done_o === 1'b1) begin
                if_lat = cyc - start;
                if_rd  = bus.if_data_o;
                if_pend = 1'b0;
                bus.if_ce_i = 1'b0;
            end
        end
        checkOutput("handshake_timeout", 32'(mem_pend | if_pend), 32'd0);
        bus.mem_ce_i = 1'b0;
        bus.if_ce_i  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ml;
        int il;
        int seen;
        int r;
        bit dm;
        bit di;
        logic [31:0] md;
        logic [31:0] id;
        logic [31:0] a;
        logic [31:0] fa;
        logic [2:0] sel;
        logic [7:0] saved;

        rst = 1'b1;
        bus.mem_ce_i = 1'b0;
        bus.mem_we_i = 1'b0;
        bus.mem_addr_i = 32'd0;
        bus.mem_sel_i = 3'b000;
        bus.mem_data_i = 32'd0;
        bus.if_ce_i = 1'b0;
        bus.if_addr_i = 32'd0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            env_mem[i]   = 8'($urandom);
            model_mem[i] = env_mem[i];
        end
        for (int i = 0; i < 32; i++) clearSlot(i);
        preload(17'h00100, 8'h11);
        preload(17'h00101, 8'h22);
        preload(17'h00102, 8'h33);
        preload(17'h00103, 8'h44);
        preload(17'h00203, 8'hA5);
        preload(17'h1FFFE, 8'h5A);
        preload(17'h1FFFF, 8'h6B);
        preload(17'h00000, 8'h7C);
        preload(17'h00001, 8'h8D);

        repeat (3) @(negedge clk);
        checkOutput("reset_mem_data", bus.mem_data_o, 32'd0);
        checkOutput("reset_if_data", bus.if_data_o, 32'd0);
        checkOutput("reset_ram_addr", 32'(bus.ram_addr_o), 32'd0);
        checkOutput("reset_outputs", {28'd0, bus.mem_done_o, bus.if_done_o, bus.mem_busy_o, bus.ram_wr_o}, 32'd0);
        rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 32'h100, 3'b100, 32'd0, 1'b0, 32'd0, ml, md, il, id);
        checkOutput("lw_latency", 32'(ml), 32'd6);
        checkOutput("lw_data", md, 32'h44332211);

        applyStimulus(1'b1, 1'b0, 32'h203, 3'b001, 32'd0, 1'b0, 32'd0, ml, md, il, id);
        checkOutput("lb_latency", 32'(ml), 32'd3);
        checkOutput("lb_data", md, 32'h000000A5);

        applyStimulus(1'b1, 1'b1, 32'h10, 3'b010, 32'h0000BEEF, 1'b0, 32'd0, ml, md, il, id);
        checkOutput("sh_latency", 32'(ml), 32'd3);
        checkOutput("sh_byte0", 32'(env_mem[17'h10]), 32'hEF);
        checkOutput("sh_byte1", 32'(env_mem[17'h11]), 32'hBE);

        applyStimulus(1'b1, 1'b0, 32'h10, 3'b010, 32'd0, 1'b0, 32'd0, ml, md, il, id);
        checkOutput("lh_latency", 32'(ml), 32'd4);
        checkOutput("lh_data", md, 32'h0000BEEF);

        applyStimulus(1'b1, 1'b1, 32'h20, 3'b100, 32'h12345678, 1'b1, 32'h100, ml, md, il, id);
        checkOutput("arb_sw_latency", 32'(ml), 32'd5);
        checkOutput("arb_if_latency", 32'(il), 32'd12);
        checkOutput("arb_if_data", id, 32'h44332211);

        applyStimulus(1'b0, 1'b0, 32'd0, 3'b000, 32'd0, 1'b1, 32'hFFFFFFFE, ml, md, il, id);
        checkOutput("wrap_latency", 32'(il), 32'd6);
        checkOutput("wrap_data", id, 32'h8D7C6B5A);

        // Store interrupted by reset in its third cycle: two bytes land, no completion.
        saved = env_mem[17'h42];
        @(negedge clk);
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = 1'b1;
        bus.mem_addr_i = 32'h40;
        bus.mem_sel_i  = 3'b100;
        bus.mem_data_i = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.mem_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_wr_off", 32'(bus.ram_wr_o), 32'd0);
        seen = int'(bus.mem_done_o);
        repeat (8) begin
            @(negedge clk);
            seen += int'(bus.mem_done_o);
        end
        checkOutput("rst_no_done", 32'(seen), 32'd0);
        checkOutput("rst_byte0", 32'(env_mem[17'h40]), 32'h0D);
        checkOutput("rst_byte1", 32'(env_mem[17'h41]), 32'hF0);
        checkOutput("rst_byte2", 32'(env_mem[17'h42]), 32'(saved));

        applyStimulus(1'b1, 1'b0, 32'h20, 3'b100, 32'd0, 1'b0, 32'd0, ml, md, il, id);
        checkOutput("post_rst_latency", 32'(ml), 32'd6);
        checkOutput("post_rst_data", md, 32'h12345678);

        for (int it = 0; it < 250; it++) begin
            r  = $urandom_range(0, 9);
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            fa = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            case ($urandom_range(0, 3))
                0:       sel = 3'b001;
                1:       sel = 3'b010;
                2:       sel = 3'b100;
                default: sel = 3'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (r == 0) begin
                @(negedge clk);
                bus.mem_ce_i   = 1'($urandom_range(0, 1));
                bus.mem_we_i   = 1'($urandom_range(0, 1));
                bus.mem_addr_i = a;
                bus.mem_sel_i  = sel;
                bus.mem_data_i = $urandom;
                bus.if_ce_i    = !bus.mem_ce_i || ($urandom_range(0, 1) == 1);
                bus.if_addr_i  = fa;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                rst = 1'b1;
                bus.mem_ce_i = 1'b0;
                bus.if_ce_i  = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                dm = (r != 1);
                di = (r == 1) || (r >= 7);
                applyStimulus(dm, 1'($urandom_range(0, 1)), a, sel, $urandom, di, fa, ml, md, il, id);
            end
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
